// File: rtl/register_writeback.sv
// Write-side front end of the register file: merges load and ALU results into
// an in-order queue that drives the single bank write port, one write per cycle.

module register_writeback_checker #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input logic             clk,
   input logic             rst,
   input logic [CNT_W-1:0] count,
   input logic [1:0]       push_n,
   input logic             pop
);
   queue_no_overflow : assert property (@(posedge clk) disable iff (rst)
      (int'(count) + int'(push_n) - int'(pop)) <= FIFO_DEPTH);
   queue_no_underflow : assert property (@(posedge clk) disable iff (rst)
      (int'(count) + int'(push_n)) >= int'(pop));
endmodule

module register_writeback #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                load_valid,
   output logic                                load_ready,
   input  logic [ADDRESS_WIDTH-1:0]            load_address,
   input  logic [DATA_WIDTH-1:0]               load_data,
   input  logic                                alu_valid,
   output logic                                alu_ready,
   input  logic [ADDRESS_WIDTH-1:0]            alu_address,
   input  logic [DATA_WIDTH-1:0]               alu_data,
   output logic                                write_enable,
   output logic [ADDRESS_WIDTH-1:0]            write_address,
   output logic [DATA_WIDTH-1:0]               write_data,
   output logic [2**ADDRESS_WIDTH-1:0]         pending_mask,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     queue_count
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int REGS  = 2**ADDRESS_WIDTH;

   function automatic logic [REGS-1:0] one_hot(input logic [ADDRESS_WIDTH-1:0] a);
      logic [REGS-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction

   logic [ADDRESS_WIDTH-1:0] addr_mem_r [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]    data_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]         rd_ptr_r;
   logic [PTR_W-1:0]         wr_ptr_r;
   logic [CNT_W-1:0]         count_r;
   logic                     init_done_r;
   logic [CNT_W-1:0]         free_s;
   logic [CNT_W-1:0]         count_next_s;
   logic                     load_push_s;
   logic                     alu_push_s;
   logic                     pop_s;
   logic [1:0]               push_n_s;
   logic [PTR_W-1:0]         alu_slot_s;
   logic [REGS-1:0]          mask_s;

   // Ready looks only at pre-pop occupancy; init_done_r holds it low the cycle after reset.
   assign free_s       = CNT_W'(FIFO_DEPTH) - count_r;
   assign load_ready   = !rst && init_done_r && (free_s >= CNT_W'(1));
   assign alu_ready    = !rst && init_done_r && (free_s >= CNT_W'(2));

   // Writes to r0 handshake normally but never occupy an entry.
   assign load_push_s  = load_valid && load_ready && (load_address != '0);
   assign alu_push_s   = alu_valid && alu_ready && (alu_address != '0);
   assign push_n_s     = {1'b0, load_push_s} + {1'b0, alu_push_s};
   assign pop_s        = (count_r != '0);
   assign count_next_s = count_r + CNT_W'(push_n_s) - CNT_W'(pop_s);
   assign alu_slot_s   = load_push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;

   // Pointer, occupancy and post-reset ready gating.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_r    <= '0;
         wr_ptr_r    <= '0;
         count_r     <= '0;
         init_done_r <= 1'b0;
      end else begin
         init_done_r <= 1'b1;
         count_r     <= count_next_s;
         wr_ptr_r    <= wr_ptr_r + PTR_W'(push_n_s);
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // Entry storage; the load result takes the older slot.
   always_ff @(posedge clk) begin
      if (load_push_s) begin
         addr_mem_r[wr_ptr_r] <= load_address;
         data_mem_r[wr_ptr_r] <= load_data;
      end
      if (alu_push_s) begin
         addr_mem_r[alu_slot_s] <= alu_address;
         data_mem_r[alu_slot_s] <= alu_data;
      end
   end

   // Pending mask: OR of destination one-hots over occupied entries.
   always_comb begin
      mask_s = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (CNT_W'(i) < count_r) begin
            mask_s = mask_s | one_hot(addr_mem_r[rd_ptr_r + PTR_W'(i)]);
         end else begin
            mask_s = mask_s;
         end
      end
   end

   assign write_enable  = !rst && pop_s;
   assign write_address = addr_mem_r[rd_ptr_r];
   assign write_data    = data_mem_r[rd_ptr_r];
   assign pending_mask  = rst ? '0 : {mask_s[REGS-1:1], 1'b0};
   assign queue_count   = rst ? '0 : count_r;

   register_writeback_checker #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_checker (
      .clk    (clk),
      .rst    (rst),
      .count  (count_r),
      .push_n (push_n_s),
      .pop    (pop_s)
   );
endmodule

// File: tb/tb_register_writeback.sv
// Randomized and directed bench for register_writeback against a queue-based model.

module tb_register_writeback;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic [AW-1:0] load_address = '0;
   logic [DW-1:0] load_data = '0;
   logic          alu_valid = 1'b0;
   logic          alu_ready;
   logic [AW-1:0] alu_address = '0;
   logic [DW-1:0] alu_data = '0;
   logic          write_enable;
   logic [AW-1:0] write_address;
   logic [DW-1:0] write_data;
   logic [15:0]   pending_mask;
   logic [2:0]    queue_count;

   always #5 clk = ~clk;

   register_writeback #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_address(load_address), .load_data(load_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_address(alu_address), .alu_data(alu_data),
      .write_enable(write_enable), .write_address(write_address),
      .write_data(write_data), .pending_mask(pending_mask),
      .queue_count(queue_count)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   nwrites = 0;
   bit   after_rst = 1'b0;
   bit   load_fire = 1'b0;
   bit   alu_fire = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: compare at negedge against the model, then advance the model at posedge.
   task automatic tick();
      logic [15:0] m;
      bit          exp_lr;
      bit          exp_ar;
      @(negedge clk);
      m = '0;
      foreach (q[i]) m[q[i].a] = 1'b1;
      m[0]   = 1'b0;
      exp_lr = !rst && !after_rst && (FD - q.size() >= 1);
      exp_ar = !rst && !after_rst && (FD - q.size() >= 2);
      check_eq("load_ready", 64'(load_ready), 64'(exp_lr));
      check_eq("alu_ready", 64'(alu_ready), 64'(exp_ar));
      check_eq("queue_count", 64'(queue_count), rst ? 64'd0 : 64'(q.size()));
      check_eq("pending_mask", 64'(pending_mask), rst ? 64'd0 : 64'(m));
      check_eq("write_enable", 64'(write_enable), 64'(!rst && q.size() != 0));
      if (!rst && q.size() != 0) begin
         check_eq("write_address", 64'(write_address), 64'(q[0].a));
         check_eq("write_data", 64'(write_data), 64'(q[0].d));
      end
      if (write_enable) nwrites++;
      load_fire = load_valid && exp_lr;
      alu_fire  = alu_valid && exp_ar;
      @(posedge clk);
      if (rst) begin
         q.delete();
         after_rst = 1'b1;
         load_fire = 1'b0;
         alu_fire  = 1'b0;
      end else begin
         after_rst = 1'b0;
         if (q.size() != 0) void'(q.pop_front());
         if (load_fire && load_address != '0) q.push_back({load_address, load_data});
         if (alu_fire && alu_address != '0) q.push_back({alu_address, alu_data});
      end
      #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 20 && q.size() != 0; n++) tick();
      check_eq("drain_empty", 64'(q.size()), 64'd0);
   endtask

   task automatic do_reset();
      load_valid = 1'b0;
      alu_valid  = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int li;
      int ai;
      int done;
      do_reset();

      // Single ALU write to r5.
      alu_valid = 1'b1; alu_address = 4'd5; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 1'b0;
      check_eq("t1_we", 64'(write_enable), 64'd1);
      check_eq("t1_addr", 64'(write_address), 64'd5);
      check_eq("t1_data", 64'(write_data), 64'hDEADBEEF);
      check_eq("t1_mask5", 64'(pending_mask[5]), 64'd1);
      tick();
      check_eq("t1_we_after", 64'(write_enable), 64'd0);
      check_eq("t1_mask5_after", 64'(pending_mask[5]), 64'd0);

      // Load and ALU to r3 in the same cycle: load value first.
      load_valid = 1'b1; load_address = 4'd3; load_data = 32'h11;
      alu_valid  = 1'b1; alu_address  = 4'd3; alu_data  = 32'h22;
      tick();
      load_valid = 1'b0; alu_valid = 1'b0;
      check_eq("t2_count2", 64'(queue_count), 64'd2);
      check_eq("t2_first", 64'(write_data), 64'h11);
      tick();
      check_eq("t2_count1", 64'(queue_count), 64'd1);
      check_eq("t2_second", 64'(write_data), 64'h22);
      tick();
      check_eq("t2_count0", 64'(queue_count), 64'd0);

      // ALU write to r0 is accepted but never queued.
      alu_valid = 1'b1; alu_address = 4'd0; alu_data = 32'hFFFFFFFF;
      tick();
      alu_valid = 1'b0;
      check_eq("t3_we", 64'(write_enable), 64'd0);
      check_eq("t3_mask", 64'(pending_mask), 64'd0);
      check_eq("t3_count", 64'(queue_count), 64'd0);

      // Both producers held valid, addresses 1..8.
      nwrites = 0; li = 0; ai = 0;
      load_valid = 1'b1; load_address = 4'd1; load_data = 32'h100;
      alu_valid  = 1'b1; alu_address  = 4'd2; alu_data  = 32'h200;
      for (int c = 0; c < 40 && (li < 4 || ai < 4); c++) begin
         tick();
         if (load_fire) begin
            li++;
            load_valid   = (li < 4);
            load_address = AW'(2 * li + 1);
            load_data    = 32'h100 * (2 * li + 1);
         end
         if (alu_fire) begin
            ai++;
            alu_valid   = (ai < 4);
            alu_address = AW'(2 * ai + 2);
            alu_data    = 32'h100 * (2 * ai + 2);
         end
      end
      load_valid = 1'b0; alu_valid = 1'b0;
      drain();
      tick();
      check_eq("t4_writes", 64'(nwrites), 64'd8);

      // Reset with three queued entries drops them all.
      load_valid = 1'b1; load_address = 4'd1; load_data = 32'hA1;
      alu_valid  = 1'b1; alu_address  = 4'd2; alu_data  = 32'hA2;
      tick();
      load_address = 4'd3; load_data = 32'hA3;
      alu_address  = 4'd4; alu_data  = 32'hA4;
      tick();
      load_valid = 1'b0; alu_valid = 1'b0;
      check_eq("t5_count3", 64'(queue_count), 64'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("t5_we", 64'(write_enable), 64'd0);
      check_eq("t5_count", 64'(queue_count), 64'd0);
      check_eq("t5_mask", 64'(pending_mask), 64'd0);
      tick();
      load_valid = 1'b1; load_address = 4'd9; load_data = 32'h99;
      tick();
      load_valid = 1'b0;
      check_eq("t5_new_addr", 64'(write_address), 64'd9);
      check_eq("t5_new_data", 64'(write_data), 64'h99);
      drain();

      // Ten single loads with random spacing to wrap the pointers.
      done = 0;
      for (int c = 0; c < 200 && done < 10; c++) begin
         if (!load_valid && $urandom_range(0, 2) != 0) begin
            load_valid   = 1'b1;
            load_address = AW'($urandom_range(1, 15));
            load_data    = $urandom;
         end
         tick();
         if (load_fire) begin
            done++;
            load_valid = 1'b0;
         end
      end
      check_eq("t6_done", 64'(done), 64'd10);
      drain();

      // Random traffic with occasional resets and r0 targets.
      for (int c = 0; c < 600; c++) begin
         if (load_fire || !load_valid || $urandom_range(0, 15) == 0) begin
            load_valid   = ($urandom_range(0, 2) != 0);
            load_address = AW'($urandom_range(0, 15));
            load_data    = $urandom;
         end
         if (alu_fire || !alu_valid || $urandom_range(0, 15) == 0) begin
            alu_valid   = ($urandom_range(0, 2) != 0);
            alu_address = AW'($urandom_range(0, 15));
            alu_data    = $urandom;
         end
         rst = ($urandom_range(0, 60) == 0);
         tick();
      end
      rst = 1'b0;
      load_valid = 1'b0; alu_valid = 1'b0;
      tick();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
